// File: rtl/ff256_ct_seq_pkg.sv
// Shared types and constants for the sequential GF(2^8) cosine-transform row engine.
//   gf8_t        : one field element
//   FF256_POLY   : low byte of x^8+x^4+x^3+x^2+1
//   FF256CT_FWD  : default 8x8 forward matrix, FWD[r][k] = 2^(k-r) for k >= r, else 0
//   FF256CT_INV  : its inverse, identity plus 8'h02 on the superdiagonal
//   ct_state_t   : engine FSM states
package ff256_ct_seq_pkg;

  typedef logic [7:0] gf8_t;

  localparam gf8_t FF256_POLY = 8'h1D;
  localparam int unsigned FF256CT_N = 8;

  typedef gf8_t [0:FF256CT_N-1][0:FF256CT_N-1] ct_mat_t;

  typedef enum logic [0:0] {IDLE, RUN} ct_state_t;

  // FWD = sum_j (2S)^j with S the upper shift; in characteristic 2 its inverse is I + 2S.
  function automatic ct_mat_t ct_fwd_default();
    ct_mat_t m;
    for (int r = 0; r < FF256CT_N; r++) begin
      for (int k = 0; k < FF256CT_N; k++) begin
        m[r][k] = (k >= r) ? gf8_t'(8'h01 << (k - r)) : 8'h00;
      end
    end
    return m;
  endfunction

  function automatic ct_mat_t ct_inv_default();
    ct_mat_t m;
    for (int r = 0; r < FF256CT_N; r++) begin
      for (int k = 0; k < FF256CT_N; k++) begin
        m[r][k] = (k == r) ? 8'h01 : ((k == r + 1) ? 8'h02 : 8'h00);
      end
    end
    return m;
  endfunction

  localparam ct_mat_t FF256CT_FWD = ct_fwd_default();
  localparam ct_mat_t FF256CT_INV = ct_inv_default();

endpackage

// File: rtl/ff256_gf_mult.sv
// Combinational GF(2^8) multiplier, p = a * b reduced by POLY.
//   a, b : operands
//   p    : product
module ff256_gf_mult
  import ff256_ct_seq_pkg::*;
#(
  parameter gf8_t POLY = FF256_POLY
) (
  input  gf8_t a,
  input  gf8_t b,
  output gf8_t p
);

  always_comb begin
    gf8_t acc;
    gf8_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      // multiply sh by x, folding the overflow bit back in through POLY
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ POLY) : {sh[6:0], 1'b0};
    end
    p = acc;
  end

endmodule

// File: rtl/ff256_ct_seq_row_engine.sv
// Sequential GF(2^8) cosine-transform engine. Accepts one N-byte vector and emits
// X[n] = XOR_k BETAS[n][k] * x[k] one row per cycle, n = 0..N-1.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input vector handshake; in_inv selects the inverse matrix
//   in_data           : x[k] = in_data[8k+7:8k]
//   out_valid/ready   : output row handshake
//   out_data/idx/last : row value, row index, last-row flag
// The package default matrices are 8x8; other N values need explicit BETAS_* overrides.
module ff256_ct_seq_row_engine
  import ff256_ct_seq_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter gf8_t POLY = FF256_POLY,
  parameter gf8_t [0:N-1][0:N-1] BETAS_FWD = FF256CT_FWD,
  parameter gf8_t [0:N-1][0:N-1] BETAS_INV = FF256CT_INV,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inv,
  input  logic [8*N-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  localparam logic [IDX_W-1:0] LastRow = IDX_W'(N - 1);

  ct_state_t        state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [8*N-1:0]   x_q, x_d;
  logic             inv_q, inv_d;
  logic             out_valid_q, out_valid_d;
  gf8_t             out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             load;

  gf8_t coef [N];
  gf8_t prod [N];
  gf8_t row_sum;

  // One multiplier per lane; coefficients for the current row are muxed in per cycle.
  for (genvar k = 0; k < N; k++) begin : g_lane
    assign coef[k] = inv_q ? BETAS_INV[row_q][k] : BETAS_FWD[row_q][k];
    ff256_gf_mult #(
      .POLY(POLY)
    ) u_mul (
      .a(coef[k]),
      .b(x_q[8*k +: 8]),
      .p(prod[k])
    );
  end

  always_comb begin
    row_sum = '0;
    for (int k = 0; k < N; k++) begin
      row_sum = row_sum ^ prod[k];
    end
  end

  assign in_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    x_d         = x_q;
    inv_d       = inv_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    load        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          inv_d   = in_inv;
          row_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        load = !out_valid_q || out_ready;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_data_d  = row_sum;
      out_idx_d   = row_q;
      out_last_d  = (row_q == LastRow);
      out_valid_d = 1'b1;
      if (row_q == LastRow) begin
        row_d   = '0;
        state_d = IDLE;
      end else begin
        row_d = row_q + IDX_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      x_q         <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      x_q         <= x_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_ff256_ct_seq_row_engine.sv
// Bench for ff256_ct_seq_row_engine: four engines with different matrices share one stimulus
// stream; a transaction-level model predicts every cycle and literal vectors pin the model.
module tb_ff256_ct_seq_row_engine;
  import ff256_ct_seq_pkg::*;

  localparam int unsigned N = 8;
  localparam int NI = 4;
  typedef gf8_t [0:N-1][0:N-1] mat_t;

  // kind 0: identity, 1: all 8'h01, 2: all 8'h02
  function automatic mat_t mk_mat(int kind);
    mat_t m;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        if (kind == 0) m[r][k] = (r == k) ? 8'h01 : 8'h00;
        else if (kind == 1) m[r][k] = 8'h01;
        else m[r][k] = 8'h02;
      end
    end
    return m;
  endfunction

  localparam mat_t M_ID  = mk_mat(0);
  localparam mat_t M_ONE = mk_mat(1);
  localparam mat_t M_TWO = mk_mat(2);

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_inv;
  logic [63:0]  in_data;
  logic         out_ready;
  logic         rdy [NI];
  logic         ov  [NI];
  gf8_t         od  [NI];
  logic [2:0]   oi  [NI];
  logic         ol  [NI];

  ff256_ct_seq_row_engine #(.N(N), .BETAS_FWD(M_ID)) u_id (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_idx(oi[0]), .out_last(ol[0])
  );
  ff256_ct_seq_row_engine #(.N(N), .BETAS_FWD(M_ONE), .BETAS_INV(M_ID)) u_one (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_idx(oi[1]), .out_last(ol[1])
  );
  ff256_ct_seq_row_engine #(.N(N), .BETAS_FWD(M_TWO)) u_two (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_idx(oi[2]), .out_last(ol[2])
  );
  ff256_ct_seq_row_engine #(.N(N)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]),
    .out_idx(oi[3]), .out_last(ol[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Field arithmetic through exp/log tables of the generator 2.
  int exp_t [255];
  int log_t [256];

  function automatic gf8_t gmul(gf8_t a, gf8_t b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return gf8_t'(exp_t[(log_t[a] + log_t[b]) % 255]);
  endfunction

  mat_t fwd_m [NI];
  mat_t inv_m [NI];

  // Model: rows still to be presented, the row currently on the output, expected values.
  int   m_left;
  int   m_next;
  logic m_ov;
  int   m_idx;
  gf8_t m_rows [NI][N];
  gf8_t m_data [NI];

  // Outputs seen at the last falling edge, and the rows actually handed downstream.
  logic s_ov [NI];
  gf8_t s_od [NI];
  int   s_oi0;
  gf8_t log_q [NI][$];
  int   idx_log [$];

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0h required=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (s_ov[i] && out_ready) begin
        log_q[i].push_back(s_od[i]);
        if (i == 0) idx_log.push_back(s_oi0);
      end
    end
    if (rst) begin
      m_left = 0;
      m_next = 0;
      m_ov   = 1'b0;
      m_idx  = 0;
      for (int i = 0; i < NI; i++) m_data[i] = 8'h00;
    end else if (m_left > 0 && (!m_ov || out_ready)) begin
      m_ov  = 1'b1;
      m_idx = m_next;
      for (int i = 0; i < NI; i++) m_data[i] = m_rows[i][m_next];
      m_next++;
      m_left--;
    end else begin
      if (m_ov && out_ready) m_ov = 1'b0;
      if (m_left == 0 && in_valid) begin
        for (int i = 0; i < NI; i++) begin
          for (int n = 0; n < N; n++) begin
            gf8_t acc;
            acc = 8'h00;
            for (int k = 0; k < N; k++) begin
              acc ^= gmul(in_inv ? inv_m[i][n][k] : fwd_m[i][n][k], in_data[8*k +: 8]);
            end
            m_rows[i][n] = acc;
          end
        end
        m_left = N;
        m_next = 0;
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < NI; i++) begin
      chk("in_ready", i, 32'(rdy[i]), 32'((m_left == 0) && !rst));
      chk("out_valid", i, 32'(ov[i]), 32'(m_ov));
      if (m_ov) begin
        chk("out_data", i, 32'(od[i]), 32'(m_data[i]));
        chk("out_idx", i, 32'(oi[i]), 32'(m_idx));
        chk("out_last", i, 32'(ol[i]), 32'(m_idx == N - 1));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    for (int i = 0; i < NI; i++) begin
      s_ov[i] = ov[i];
      s_od[i] = od[i];
    end
    s_oi0 = int'(oi[0]);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) log_q[i].delete();
    idx_log.delete();
  endtask

  // Present one vector and run until the engine is idle with an empty output stage.
  task automatic run_vec(input logic [63:0] d, input logic inv, input logic toggle,
                         output int low_cnt);
    bit done;
    clear_logs();
    low_cnt  = 0;
    done     = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (!rdy[0]) low_cnt++;
      in_valid = 1'b0;
      if (toggle) in_inv = !inv;
      if (m_left == 0 && !m_ov) done = 1;
    end
    if (!done) chk("run_timeout", 0, 32'd0, 32'd1);
  endtask

  task automatic wait_row(input int r);
    bit hit;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (ov[0] && int'(oi[0]) == r) hit = 1;
      else tick();
    end
    if (!hit) chk("wait_row_timeout", 0, 32'd0, 32'd1);
  endtask

  task automatic chk_log_seq(string nm, int i, logic [7:0] base, logic [7:0] step);
    chk({nm, "_len"}, i, 32'(log_q[i].size()), 32'(N));
    for (int n = 0; n < N && n < log_q[i].size(); n++) begin
      chk(nm, i, 32'(log_q[i][n]), 32'(8'(base + step * 8'(n))));
    end
  endtask

  localparam logic [63:0] X18 = 64'h0807060504030201;

  initial begin
    int lows;
    int e;
    checks   = 0;
    failures = 0;
    e = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e << 1;
      if ((e & 'h100) != 0) e ^= 'h11D;
    end
    fwd_m[0] = M_ID;        inv_m[0] = FF256CT_INV;
    fwd_m[1] = M_ONE;       inv_m[1] = M_ID;
    fwd_m[2] = M_TWO;       inv_m[2] = FF256CT_INV;
    fwd_m[3] = FF256CT_FWD; inv_m[3] = FF256CT_INV;
    m_left = 0; m_next = 0; m_ov = 1'b0; m_idx = 0; s_oi0 = 0;
    for (int i = 0; i < NI; i++) begin
      m_data[i] = 8'h00;
      s_ov[i]   = 1'b0;
      s_od[i]   = 8'h00;
    end

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_data", 0, 32'(od[0]), 32'h00);
    chk("rst_out_idx", 0, 32'(oi[0]), 32'h0);
    chk("rst_out_last", 0, 32'(ol[0]), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 0, 32'(rdy[0]), 32'h1);
    tick();

    // identity / all-01 / all-02 on 01..08
    run_vec(X18, 1'b0, 1'b0, lows);
    chk("id_ready_low", 0, 32'(lows), 32'd8);
    chk_log_seq("id_rows", 0, 8'h01, 8'h01);
    chk_log_seq("one_rows", 1, 8'h08, 8'h00);
    chk_log_seq("two_rows", 2, 8'h10, 8'h00);
    for (int n = 0; n < N && n < idx_log.size(); n++) chk("id_idx", 0, 32'(idx_log[n]), 32'(n));

    // single 0x80 in lane 0: 0x02*0x80 wraps through POLY
    run_vec(64'h80, 1'b0, 1'b0, lows);
    chk_log_seq("two_x80", 2, 8'h1D, 8'h00);
    chk_log_seq("one_x80", 1, 8'h80, 8'h00);
    if (log_q[0].size() > 1) begin
      chk("id_x80_r0", 0, 32'(log_q[0][0]), 32'h80);
      chk("id_x80_r1", 0, 32'(log_q[0][1]), 32'h00);
    end

    // inverse mode, in_inv flipped while running
    run_vec(X18, 1'b1, 1'b1, lows);
    chk_log_seq("inv_rows", 1, 8'h01, 8'h01);

    // backpressure on row 2, with an ignored vector offered meanwhile
    clear_logs();
    in_valid = 1'b1; in_data = X18; in_inv = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_row(2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_data", 0, 32'(od[0]), 32'h03);
      chk("hold_idx", 0, 32'(oi[0]), 32'h2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    chk_log_seq("bp_rows", 0, 8'h01, 8'h01);

    // reset while row 4 is on the output
    in_valid = 1'b1; in_data = X18;
    tick();
    in_valid = 1'b0;
    wait_row(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_valid", 0, 32'(ov[0]), 32'h0);
    chk("abort_idx", 0, 32'(oi[0]), 32'h0);
    chk("abort_ready", 0, 32'(rdy[0]), 32'h1);
    run_vec(X18, 1'b0, 1'b0, lows);
    chk_log_seq("post_rst", 0, 8'h01, 8'h01);

    // in_valid together with rst captures nothing
    rst = 1'b1; in_valid = 1'b1; in_data = X18;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst_wins", 0, 32'(ov[0]), 32'h0);

    // package default matrices, both directions, model-checked only
    run_vec(64'h3C5A_9601_FF7E_2B10, 1'b0, 1'b0, lows);
    run_vec(64'h3C5A_9601_FF7E_2B10, 1'b1, 1'b0, lows);
    run_vec(64'h0, 1'b0, 1'b0, lows);
    chk_log_seq("zero_in", 3, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
